// File: rtl/ob_pkg.sv
// Shared order-book types: command encoding, uid, table size default, stop-op helper.
// OB_CN_TABLE_SCHED_STATS_EN adds the conditional-table statistics pair type.
package ob_pkg;

  localparam int OB_CN_TABLE_N = 16;

  typedef enum logic [3:0] {
    Op_Nop           = 4'd0,
    Op_BuyMarket     = 4'd1,
    Op_SellMarket    = 4'd2,
    Op_BuyLimit      = 4'd3,
    Op_SellLimit     = 4'd4,
    Op_BuyStopLoss   = 4'd5,
    Op_SellStopLoss  = 4'd6,
    Op_BuyStopLimit  = 4'd7,
    Op_SellStopLimit = 4'd8
  } opcode_t;

  typedef logic [15:0] uid_t;

  typedef struct packed {
    opcode_t     opcode;
    uid_t        uid;
    logic [15:0] price;
    logic [15:0] qty;
  } cmd_t;

  function automatic logic is_stop_op(opcode_t op);
    return (op == Op_BuyStopLoss)  || (op == Op_SellStopLoss) ||
           (op == Op_BuyStopLimit) || (op == Op_SellStopLimit);
  endfunction

`ifdef OB_CN_TABLE_SCHED_STATS_EN
  typedef struct packed {
    logic [31:0] mtr_cnt;
    logic [31:0] cancel_cnt;
  } cn_tbl_stat_t;
`endif

endpackage

// File: rtl/ob_cn_rr_arb.sv
// N-bit round-robin arbiter: searches upward from an internal pointer with wrap,
// emits a one-hot grant, and moves the pointer past the winner when adv_en is set.
module ob_cn_rr_arb #(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 adv_en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d, idx;

  // first requester at or above the pointer, wrapping (N is a power of 2)
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + IW'(k);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    for (int i = 0; i < N; i++) gnt[i] = gnt_vld && (gnt_idx == IW'(i));
    ptr_d = (adv_en && gnt_vld) ? gnt_idx + 1'b1 : ptr_q;
  end

  // pointer register
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ob_cn_table_sched.sv
// Conditional (stop-order) table controller: lowest-free allocation, round-robin
// issue of matured entries through a registered valid/ready slot, cancel aggregation.
// Optional statistics counters under OB_CN_TABLE_SCHED_STATS_EN.
module ob_cn_table_sched
  import ob_pkg::*;
#(
  parameter int N     = OB_CN_TABLE_N,
  parameter int CNT_W = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  cmd_t             in_cmd,
  output logic             in_rdy,
  output logic [N-1:0]     ent_al_vld,
  output cmd_t             ent_al_cmd,
  output logic [N-1:0]     ent_dl_vld,
  input  logic [N-1:0]     ent_busy_w,
  input  logic [N-1:0]     ent_mtr_vld_w,
  input  cmd_t [N-1:0]     ent_cmd_r,
  input  logic [N-1:0]     ent_cancel_hit,
  input  logic             cancel,
  input  uid_t             cancel_uid,
  output logic             cancel_hit,
  output logic             out_vld,
  output cmd_t             out_cmd,
  input  logic             out_rdy,
  output logic             full_r,
  output logic             empty_r,
  output logic [CNT_W-1:0] cnt_r
`ifdef OB_CN_TABLE_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_mtr_cnt_r,
  output logic [31:0]      stat_cancel_cnt_r
`endif
);

  localparam int IW = $clog2(N);

  logic [N-1:0]     busy_q, mtr_q;
  logic             out_vld_q, out_vld_d;
  cmd_t             out_cmd_q, out_cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d, empty_q, empty_d;

  logic             al_found, out_cancel, slot_free, pick, gnt_vld;
  logic [N-1:0]     cand, gnt;
  logic [IW-1:0]    gnt_idx;

  assign in_rdy     = ~full_q;
  assign ent_al_cmd = in_cmd;

  // one-hot allocate at the lowest idle entry
  always_comb begin
    ent_al_vld = '0;
    al_found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!al_found && !busy_q[i]) begin
        al_found      = 1'b1;
        ent_al_vld[i] = in_vld & ~full_q;
      end
    end
  end

  // an entry being cancelled this cycle must not be picked
  assign cand       = mtr_q & ~ent_cancel_hit;
  // a cancelled output kills the pending transfer and frees the slot for a new pick
  assign out_cancel = cancel & out_vld_q & (out_cmd_q.uid == cancel_uid);
  assign slot_free  = ~out_vld_q | out_rdy | out_cancel;
  assign pick       = slot_free & gnt_vld;
  assign cancel_hit = (|ent_cancel_hit) | out_cancel;
  assign ent_dl_vld = pick ? gnt : '0;

  ob_cn_rr_arb #(.N(N)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (cand),
    .adv_en  (pick),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // output slot next state and status derived from entry next-state
  always_comb begin
    out_vld_d = out_vld_q;
    out_cmd_d = out_cmd_q;
    if (pick) begin
      out_vld_d = 1'b1;
      out_cmd_d = ent_cmd_r[gnt_idx];
    end else if (slot_free) begin
      out_vld_d = 1'b0;
    end
    cnt_d   = CNT_W'($countones(ent_busy_w));
    full_d  = &ent_busy_w;
    empty_d = ~(|ent_busy_w) & ~out_vld_d;
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      mtr_q     <= '0;
      out_vld_q <= 1'b0;
      out_cmd_q <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      busy_q    <= ent_busy_w;
      mtr_q     <= ent_mtr_vld_w;
      out_vld_q <= out_vld_d;
      out_cmd_q <= out_cmd_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_cmd = out_cmd_q;
  assign cnt_r   = cnt_q;
  assign full_r  = full_q;
  assign empty_r = empty_q;

`ifdef OB_CN_TABLE_SCHED_STATS_EN
  cn_tbl_stat_t stat_q, stat_d;

  // saturating counters: completed (uncancelled) transfers and cancel-hit cycles
  always_comb begin
    stat_d = stat_q;
    if (out_vld_q && out_rdy && !out_cancel && (stat_q.mtr_cnt != '1))
      stat_d.mtr_cnt = stat_q.mtr_cnt + 32'd1;
    if (cancel_hit && (stat_q.cancel_cnt != '1))
      stat_d.cancel_cnt = stat_q.cancel_cnt + 32'd1;
  end

  // statistics registers
  always_ff @(posedge clk) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_mtr_cnt_r    = stat_q.mtr_cnt;
  assign stat_cancel_cnt_r = stat_q.cancel_cnt;
`endif

endmodule

// File: tb/tb_ob_cn_table_sched.sv
// Bench for ob_cn_table_sched (N=4): emulated entries, per-cycle behavioural model, directed scenarios.
module tb_ob_cn_table_sched;
  import ob_pkg::*;

  localparam int N  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_vld, in_rdy, cancel, cancel_hit, out_vld, out_rdy;
  logic          full_r, empty_r;
  logic [CW-1:0] cnt_r;
  cmd_t          in_cmd, ent_al_cmd, out_cmd;
  uid_t          cancel_uid;
  logic [N-1:0]  ent_al_vld, ent_dl_vld, ent_busy_w, ent_mtr_vld_w, ent_cancel_hit;
  cmd_t [N-1:0]  ent_cmd_r;
`ifdef OB_CN_TABLE_SCHED_STATS_EN
  logic [31:0]   stat_mtr_cnt_r, stat_cancel_cnt_r;
`endif

  ob_cn_table_sched #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_cmd(in_cmd), .in_rdy(in_rdy),
    .ent_al_vld(ent_al_vld), .ent_al_cmd(ent_al_cmd), .ent_dl_vld(ent_dl_vld),
    .ent_busy_w(ent_busy_w), .ent_mtr_vld_w(ent_mtr_vld_w), .ent_cmd_r(ent_cmd_r),
    .ent_cancel_hit(ent_cancel_hit), .cancel(cancel), .cancel_uid(cancel_uid),
    .cancel_hit(cancel_hit), .out_vld(out_vld), .out_cmd(out_cmd), .out_rdy(out_rdy),
    .full_r(full_r), .empty_r(empty_r), .cnt_r(cnt_r)
`ifdef OB_CN_TABLE_SCHED_STATS_EN
    , .stat_mtr_cnt_r(stat_mtr_cnt_r), .stat_cancel_cnt_r(stat_cancel_cnt_r)
`endif
  );

  // ---------------- entry emulation ----------------
  logic [N-1:0] e_busy, e_mtr, mature_req;
  logic         rearm;
  cmd_t [N-1:0] e_cmd;

  function automatic cmd_t permute(cmd_t c);
    cmd_t r = c;
    case (c.opcode)
      Op_BuyStopLoss:   r.opcode = Op_BuyMarket;
      Op_SellStopLoss:  r.opcode = Op_SellMarket;
      Op_BuyStopLimit:  r.opcode = Op_BuyLimit;
      Op_SellStopLimit: r.opcode = Op_SellLimit;
      default:          r.opcode = c.opcode;
    endcase
    return r;
  endfunction

  function automatic cmd_t mk(opcode_t op, int uid);
    cmd_t c;
    c.opcode = op;
    c.uid    = uid_t'(uid);
    c.price  = 16'(100 + uid);
    c.qty    = 16'(10 * uid);
    return c;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++)
      ent_cancel_hit[i] = cancel && e_busy[i] && (e_cmd[i].uid == cancel_uid);
    ent_busy_w    = (e_busy | ent_al_vld) & ~ent_cancel_hit & ~(rearm ? '0 : ent_dl_vld);
    ent_mtr_vld_w = (e_mtr | mature_req) & ent_busy_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_busy <= '0;
      e_mtr  <= '0;
      e_cmd  <= '0;
    end else begin
      e_busy <= ent_busy_w;
      e_mtr  <= ent_mtr_vld_w;
      for (int i = 0; i < N; i++) if (ent_al_vld[i]) e_cmd[i] <= permute(in_cmd);
    end
  end
  assign ent_cmd_r = e_cmd;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: state seen after the last edge
  logic [N-1:0]  m_busy, m_mtr;
  int            m_ptr;
  logic          m_ov, m_full, m_empty;
  cmd_t          m_oc;
  logic [CW-1:0] m_cnt;

  always @(negedge clk) begin
    logic [N-1:0] x_al, x_dl, cnd;
    logic         ocan, slot, rdy, pick;
    int           g, p;
    rdy  = (m_busy != {N{1'b1}});
    x_al = '0;
    if (in_vld && rdy)
      for (int i = N-1; i >= 0; i--) if (!m_busy[i]) x_al = N'(1) << i;
    ocan = cancel && m_ov && (m_oc.uid == cancel_uid);
    slot = !m_ov || out_rdy || ocan;
    cnd  = m_mtr & ~ent_cancel_hit;
    g = -1;
    for (int k = 0; k < N; k++) begin
      p = (m_ptr + k) % N;
      if (g < 0 && cnd[p]) g = p;
    end
    pick = slot && (g >= 0);
    x_dl = pick ? (N'(1) << g) : '0;
    if (started) begin
      chk("m_in_rdy",     in_rdy,     rdy);
      chk("m_al_vld",     ent_al_vld, x_al);
      chk("m_al_cmd",     ent_al_cmd, in_cmd);
      chk("m_dl_vld",     ent_dl_vld, x_dl);
      chk("m_cancel_hit", cancel_hit, (|ent_cancel_hit) | ocan);
      chk("m_out_vld",    out_vld,    m_ov);
      chk("m_out_cmd",    out_cmd,    m_oc);
      chk("m_full",       full_r,     m_full);
      chk("m_empty",      empty_r,    m_empty);
      chk("m_cnt",        cnt_r,      m_cnt);
    end
    if (rst) begin
      m_busy = '0; m_mtr = '0; m_ptr = 0; m_ov = 1'b0; m_oc = '0;
      m_cnt = '0; m_full = 1'b0; m_empty = 1'b1;
    end else begin
      m_busy = ent_busy_w;
      m_mtr  = ent_mtr_vld_w;
      if (pick) begin
        m_ov  = 1'b1;
        m_oc  = ent_cmd_r[g];
        m_ptr = (g + 1) % N;
      end else if (slot) begin
        m_ov = 1'b0;
      end
      m_cnt   = CW'($countones(ent_busy_w));
      m_full  = (ent_busy_w == {N{1'b1}});
      m_empty = (ent_busy_w == '0) && !m_ov;
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    opcode_t ops [5];
    ops = '{Op_SellStopLoss, Op_BuyStopLoss, Op_BuyStopLimit, Op_SellStopLimit, Op_BuyStopLoss};
    rst = 1'b1; in_vld = 1'b0; in_cmd = '0; cancel = 1'b0; cancel_uid = '0;
    out_rdy = 1'b1; mature_req = '0; rearm = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; started = 1'b1;
    @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_cnt",     cnt_r,   0);
    chk("rst_empty",   empty_r, 1);
    chk("rst_full",    full_r,  0);
    chk("rst_in_rdy",  in_rdy,  1);

    // alloc fill: uid 1..5, fifth stalls on full
    for (int i = 0; i < 5; i++) begin
      nxt(); in_vld = 1'b1; in_cmd = mk(ops[i], i + 1);
      @(negedge clk);
      if (i < 4) chk("fill_al", ent_al_vld, 64'(1) << i);
      else begin
        chk("fill_al_stall", ent_al_vld, 0);
        chk("fill_full",     full_r,     1);
        chk("fill_in_rdy",   in_rdy,     0);
        chk("fill_cnt",      cnt_r,      4);
      end
    end

    // maturity issue: entries 1 and 3 together, pointer at 0
    nxt(); in_vld = 1'b0; mature_req = 4'b1010;
    nxt(); mature_req = '0;
    @(negedge clk); chk("mat_dl0", ent_dl_vld, 4'b0010);
    nxt(); @(negedge clk);
    chk("mat_vld0", out_vld, 1);
    chk("mat_op0",  out_cmd.opcode, Op_BuyMarket);
    chk("mat_uid0", out_cmd.uid, 2);
    chk("mat_dl1",  ent_dl_vld, 4'b1000);
    nxt(); @(negedge clk);
    chk("mat_op1",  out_cmd.opcode, Op_SellLimit);
    chk("mat_uid1", out_cmd.uid, 4);
    nxt(); @(negedge clk);
    chk("mat_idle", out_vld, 0);
    chk("mat_cnt",  cnt_r, 2);

    // backpressure: entries 0 and 2 matured, out_rdy low for 3 cycles
    nxt(); out_rdy = 1'b0; mature_req = 4'b0101;
    nxt(); mature_req = '0;
    @(negedge clk); chk("bp_dl0", ent_dl_vld, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      nxt(); @(negedge clk);
      chk("bp_hold_vld", out_vld, 1);
      chk("bp_hold_uid", out_cmd.uid, 1);
      chk("bp_hold_dl",  ent_dl_vld, 0);
    end
    nxt(); out_rdy = 1'b1;
    @(negedge clk); chk("bp_dl2", ent_dl_vld, 4'b0100);
    nxt(); @(negedge clk);
    chk("bp_uid2", out_cmd.uid, 3);
    chk("bp_op2",  out_cmd.opcode, Op_BuyLimit);

    // round-robin fairness: entries 0 and 1 re-mature continuously
    nxt(); in_vld = 1'b1; in_cmd = mk(Op_BuyStopLoss, 8);
    @(negedge clk); chk("rr_al0", ent_al_vld, 4'b0001);
    nxt(); in_cmd = mk(Op_SellStopLoss, 9);
    @(negedge clk); chk("rr_al1", ent_al_vld, 4'b0010);
    nxt(); in_vld = 1'b0; rearm = 1'b1; mature_req = 4'b0011;
    nxt(); mature_req = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("rr_dl", ent_dl_vld, (k % 2) ? 4'b0010 : 4'b0001);
      nxt();
    end
    rearm = 1'b0;
    repeat (4) nxt();

    // cancel of the command held in the output register
    in_vld = 1'b1; in_cmd = mk(Op_BuyStopLimit, 7); out_rdy = 1'b0;
    @(negedge clk); chk("cx_al", ent_al_vld, 4'b0001);
    nxt(); in_vld = 1'b0; mature_req = 4'b0001;
    nxt(); mature_req = '0;
    nxt(); @(negedge clk);
    chk("cx_held_vld", out_vld, 1);
    chk("cx_held_uid", out_cmd.uid, 7);
    nxt(); cancel = 1'b1; cancel_uid = 16'd7;
    @(negedge clk); chk("cx_hit", cancel_hit, 1);
    nxt(); cancel = 1'b0;
    @(negedge clk); chk("cx_out_clr", out_vld, 0);

    // cancel of a matured, not yet picked entry
    nxt(); out_rdy = 1'b1; in_vld = 1'b1; in_cmd = mk(Op_BuyStopLoss, 10);
    @(negedge clk); chk("cy_al", ent_al_vld, 4'b0001);
    nxt(); in_vld = 1'b0; mature_req = 4'b0001;
    nxt(); mature_req = '0; cancel = 1'b1; cancel_uid = 16'd10;
    @(negedge clk);
    chk("cy_hit", cancel_hit, 1);
    chk("cy_dl",  ent_dl_vld, 0);
    nxt(); cancel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("cy_never", out_vld, 0);
      nxt();
    end
    @(negedge clk); chk("cy_cnt", cnt_r, 0);

    // reset mid-operation with out_vld=1 and cnt_r=3
    for (int i = 0; i < 4; i++) begin
      nxt(); in_vld = 1'b1; in_cmd = mk(Op_SellStopLimit, 12 + i);
    end
    nxt(); in_vld = 1'b0; out_rdy = 1'b0; mature_req = 4'b0001;
    nxt(); mature_req = '0;
    nxt(); @(negedge clk);
    chk("rm_pre_vld", out_vld, 1);
    chk("rm_pre_cnt", cnt_r, 3);
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0; out_rdy = 1'b1;
    @(negedge clk);
    chk("rm_out_vld", out_vld, 0);
    chk("rm_cnt",     cnt_r,   0);
    chk("rm_empty",   empty_r, 1);
    chk("rm_in_rdy",  in_rdy,  1);

    repeat (2) nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
